// File: rtl/turn_signal_fsm.sv
// turn_signal_fsm
//   Sequential front end of the tail-light controller. Synchronizes the
//   hazard/turn switches and the turn-side input, resolves hazard-over-turn
//   priority, and runs the blink timer. The one-hot state code it drives is
//   decoded combinationally downstream, so every bit of timing lives here.
//
// Parameters
//   HALF_PERIOD : clock cycles per blink half-period (>= 2)
//   CNT_W       : blink counter width, derived from HALF_PERIOD (do not override)
//
// Ports
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   SW[1:0]      : async switches, SW[0] = hazards, SW[1] = turn request
//   turn_side    : async, 0 = left, 1 = right
//   CurrentState : registered state code (000 idle, 001 hazards,
//                  010 left, 100 right); idle whenever blink_on = 0
//   blink_on     : registered blink phase, 1 = lamps lit
module turn_signal_fsm #(
  parameter int HALF_PERIOD = 25_000_000,
  parameter int CNT_W       = $clog2(HALF_PERIOD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] SW,
  input  logic       turn_side,
  output logic [2:0] CurrentState,
  output logic       blink_on
);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    HAZARDS    = 3'b001,
    TURN_LEFT  = 3'b010,
    TURN_RIGHT = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

  // Two-flop synchronizers; only the *_s values are used downstream.
  logic [1:0] sw_meta, sw_s;
  logic       side_meta, side_s;

  state_t           req, req_q;
  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             blink_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta   <= '0;
      sw_s      <= '0;
      side_meta <= 1'b0;
      side_s    <= 1'b0;
    end else begin
      sw_meta   <= SW;
      sw_s      <= sw_meta;
      side_meta <= turn_side;
      side_s    <= side_meta;
    end
  end

  // Hazards win over a turn request; turn_side is ignored during hazards.
  always_comb begin
    req = IDLE;
    if (sw_s[0])      req = HAZARDS;
    else if (sw_s[1]) req = side_s ? TURN_RIGHT : TURN_LEFT;
  end

  always_comb begin
    cnt_nxt   = cnt;
    blink_nxt = blink_on;
    state_nxt = state_q;
    if ((req != req_q) || (req == IDLE)) begin
      // Any request change restarts the blink in its on phase, and this
      // takes precedence over a phase end on the same edge. An idle request
      // parks the timer in the same restart condition.
      cnt_nxt   = '0;
      blink_nxt = 1'b1;
      state_nxt = req;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else begin
      // Phase end: flip the phase. The lamps go dark (IDLE code) when the
      // new phase is off, i.e. when the current phase is on.
      cnt_nxt   = '0;
      blink_nxt = ~blink_on;
      state_nxt = blink_on ? IDLE : req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= IDLE;
      cnt      <= '0;
      blink_on <= 1'b1;
      state_q  <= IDLE;
    end else begin
      req_q    <= req;
      cnt      <= cnt_nxt;
      blink_on <= blink_nxt;
      state_q  <= state_nxt;
    end
  end

  assign CurrentState = state_q;

endmodule

// File: tb/tb_turn_signal_fsm.sv
// Directed bench for turn_signal_fsm with HALF_PERIOD = 4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_turn_signal_fsm;

  logic       clk;
  logic       rst_n;
  logic [1:0] SW;
  logic       turn_side;
  logic [2:0] CurrentState;
  logic       blink_on;

  int n_chk = 0;
  int n_err = 0;

  turn_signal_fsm #(.HALF_PERIOD(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SW           (SW),
    .turn_side    (turn_side),
    .CurrentState (CurrentState),
    .blink_on     (blink_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steady request: code for 4 cycles, idle for 4, repeating. Called while
  // sitting on the first cycle of an on phase; returns n cycles later.
  task automatic blink_seq(input string tag, input logic [2:0] code, input int n);
    for (int k = 0; k < n; k++) begin
      logic on;
      on = ((k / 4) % 2) == 0;
      chk({tag, ".cs"},    32'(CurrentState), on ? 32'(code) : 32'd0);
      chk({tag, ".blink"}, 32'(blink_on),     32'(on));
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b1; SW = 2'b00; turn_side = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.cs",    32'(CurrentState), 32'd0);
    chk("rst.blink", 32'(blink_on),     32'd1);
    tick(); tick();
    rst_n = 1'b1;

    // Idle holds with the timer parked
    repeat (5) tick();
    chk("idle.cs",    32'(CurrentState), 32'd0);
    chk("idle.blink", 32'(blink_on),     32'd1);
    chk("idle.cnt",   32'(dut.cnt),      32'd0);

    // Left turn: 3-edge latency, then 4 on / 4 off / 4 on
    SW = 2'b10; turn_side = 1'b0;
    tick(); tick();
    chk("left.lat", 32'(CurrentState), 32'd0);
    tick();
    blink_seq("left", 3'b010, 12);

    // Side switch in the off phase: fresh right turn starts lit
    chk("side.off0", 32'(CurrentState), 32'd0);
    turn_side = 1'b1;
    tick(); chk("side.off1", 32'(CurrentState), 32'd0);
    tick(); chk("side.off2", 32'(CurrentState), 32'd0);
    tick();
    blink_seq("side", 3'b100, 8);

    // Release with cnt = 1 in the on phase
    chk("rel.cnt0", 32'(dut.cnt), 32'd0);
    tick();
    chk("rel.cs1",  32'(CurrentState), 32'd4);
    chk("rel.cnt1", 32'(dut.cnt),      32'd1);
    SW = 2'b00;
    tick(); tick();
    chk("rel.cs3", 32'(CurrentState), 32'd4);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("rel.cs",    32'(CurrentState), 32'd0);
      chk("rel.blink", 32'(blink_on),     32'd1);
      chk("rel.cnt",   32'(dut.cnt),      32'd0);
      tick();
    end

    // Hazards beat a right turn; side toggles do not disturb the cadence
    SW = 2'b11; turn_side = 1'b1;
    tick(); tick();
    chk("pri.lat", 32'(CurrentState), 32'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      logic on;
      on = ((k / 4) % 2) == 0;
      chk("pri.cs",    32'(CurrentState), on ? 32'd1 : 32'd0);
      chk("pri.blink", 32'(blink_on),     32'(on));
      if (k % 2 == 1) turn_side = ~turn_side;
      tick();
    end

    // Collision: hazard->right change lands on the cnt = 3 phase-end edge
    chk("col.cs0", 32'(CurrentState), 32'd1);
    tick();
    chk("col.cnt1", 32'(dut.cnt), 32'd1);
    SW = 2'b10; turn_side = 1'b1;
    tick();
    chk("col.cs2", 32'(CurrentState), 32'd1);
    tick();
    chk("col.cnt3", 32'(dut.cnt),      32'd3);
    chk("col.cs3",  32'(CurrentState), 32'd1);
    tick();
    chk("col.cnt", 32'(dut.cnt), 32'd0);
    blink_seq("col", 3'b100, 8);

    // Reset mid-blink (off phase) with hazards requested
    SW = 2'b01;
    tick(); tick(); tick();
    chk("rb.on", 32'(CurrentState), 32'd1);
    repeat (5) tick();
    chk("rb.off.blink", 32'(blink_on),     32'd0);
    chk("rb.off.cs",    32'(CurrentState), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rb.async.cs",    32'(CurrentState), 32'd1 - 32'd1);
    chk("rb.async.blink", 32'(blink_on),     32'd1);
    chk("rb.async.cnt",   32'(dut.cnt),      32'd0);
    tick(); tick();
    chk("rb.hold.cs", 32'(CurrentState), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("rb.lat", 32'(CurrentState), 32'd0);
    tick();
    blink_seq("rb", 3'b001, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/turn_signal_fsm.md
# turn_signal_fsm

Sequential front end of the tail-light controller. Synchronizes the switch and turn-side inputs, resolves hazard/turn priority, and runs the blink timer. Drives the one-hot `CurrentState` bus consumed directly by the output-logic stage, which decodes it to LEDs and the seven-segment display. All timing lives here; the downstream stage is purely combinational on `CurrentState`.

## Interface

Parameters:
- `HALF_PERIOD`, default 25_000_000: clock cycles per blink half-period (0.5 s at 50 MHz). Legal range is ≥ 2.
- `CNT_W`, default `$clog2(HALF_PERIOD)`: width of the blink counter. This is derived and must not be overridden.

Ports:
- `clk`, input, 1: the single system clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `SW`, input, 2: asynchronous switches. `SW[0]` requests hazards; `SW[1]` requests a turn.
- `turn_side`, input, 1: asynchronous. 0 = left, 1 = right.
- `CurrentState`, output, 3: state code to the output-logic stage.
  - `IDLE` = 000
  - `HAZARDS` = 001
  - `TURN_LEFT` = 010
  - `TURN_RIGHT` = 100
- `blink_on`, output, 1: current blink phase. 1 = lamps-lit phase.

## Operation

Input synchronizers:
- `SW[1:0]` and `turn_side` each pass through a 2-flop synchronizer, giving `sw_s` and `side_s`.
- Only the synchronized values are used past this point.

Request decode (combinational on the synchronized values):
- `sw_s[0]`=1 → `req` = `HAZARDS`. Hazards take priority over a turn request.
- Else `sw_s[1]`=1 → `req` = `TURN_RIGHT` if `side_s`, else `TURN_LEFT`.
- Else `req` = `IDLE`.

Registered state:
- `req_q`: the previous cycle's `req`.
- `cnt`: blink counter, `CNT_W` bits wide.
- `blink_on`: blink phase.
- `CurrentState`: output register.

Per-edge update rules, highest priority first:
1. **Request change** (`req` != `req_q`):
   - `cnt` ← 0, `blink_on` ← 1, `CurrentState` ← `req`.
   - This restarts the blink in its on phase.
   - It covers every change: idle→active, active→idle, hazard↔turn, left↔right.
2. **Idle request** (`req` == `IDLE`, no change):
   - `cnt` ← 0, `blink_on` ← 1, `CurrentState` ← `IDLE`.
3. **Active, mid-phase** (`cnt` != `HALF_PERIOD`−1):
   - `cnt` ← `cnt`+1. Everything else holds.
4. **Active, phase end** (`cnt` == `HALF_PERIOD`−1):
   - `cnt` ← 0 and `blink_on` ← ~`blink_on`.
   - `CurrentState` ← `req` if the new `blink_on` is 1, else `IDLE`.

Invariants and guarantees:
- `CurrentState` only ever holds one of the four legal codes.
- `CurrentState` is `IDLE` whenever `blink_on`=0.
- The counter never exceeds `HALF_PERIOD`−1, so there is no wrap-around ambiguity.

Reset:
- While `rst_n`=0, all of the following are forced asynchronously: synchronizer flops = 0, `req_q` = `IDLE`, `cnt` = 0, `blink_on` = 1, `CurrentState` = `IDLE`.
- Reset asserted mid-blink ends the blink immediately.
- After reset is released, a held request is treated as a fresh change and starts with the on phase.

## Timing

Request latency:
- An input change that is stable before edge N appears in `sw_s` after edge N+1.
- `CurrentState` reflects it after edge N+2, i.e. 3 edges counted from edge N.

Blink cadence, for a steady active request:
- `CurrentState` = `req` for exactly `HALF_PERIOD` cycles, then `IDLE` for exactly `HALF_PERIOD` cycles, repeating.
- Full period = 2×`HALF_PERIOD` cycles.

Release:
- Dropping all requests forces `CurrentState` = `IDLE` at the same 3-edge latency, regardless of the current phase.

Simultaneous events:
- A request change landing on the same edge as a phase end is handled by rule 1: counter cleared, phase on.
- `SW[0]` and `SW[1]` both high gives `HAZARDS`. Toggling `turn_side` during hazards has no effect, because `req` is unchanged.

Outputs are registered, with no combinational path from the inputs. Output reset values: `CurrentState` = 000, `blink_on` = 1.

## Test plan

All scenarios use `HALF_PERIOD` = 4.

- **Reset:** assert `rst_n`=0 mid-blink with `SW`=01 → `CurrentState`=000 and `blink_on`=1 asynchronously. Release with `SW`=01 held → `CurrentState`=001 3 edges after release, then the 4-on/4-off pattern.
- **Left turn:** `SW`=10, `turn_side`=0 from idle → `CurrentState`=010 after 3 edges. Then 010×4, 000×4, 010×4 cycles, with `blink_on` tracking the phase.
- **Priority:** `SW`=11, `turn_side`=1 → `CurrentState`=001. Toggling `turn_side` every 2 cycles does not perturb the 4/4 pattern.
- **Side switch mid-off-phase:** while `CurrentState`=000 in the off phase of `TURN_LEFT`, set `turn_side`=1 → 3 edges later `CurrentState`=100 for a full 4 cycles.
- **Release during on phase:** `SW` 10→00 at `cnt`=1 → `CurrentState`=000 after 3 edges, `cnt` stays 0, `blink_on`=1, and the state stays `IDLE` indefinitely.
- **Collision:** time a hazard→turn change so that `req` changes on the same edge as `cnt`=3 → `CurrentState`=`req`, `blink_on`=1, `cnt`=0, followed by a full 4-cycle on phase.
